// File: rtl/usb_gpx_pkg.sv
// Shared types and default parameters for the USB GPX pin conditioner.
package usb_gpx_pkg;

  typedef enum logic [1:0] {
    StLo,
    StQualHi,
    StHi,
    StQualLo
  } gpx_state_e;

  localparam int unsigned SyncStagesDefault   = 2;
  localparam int unsigned FilterCyclesDefault = 4;
  localparam int unsigned CntWDefault         = 8;

endpackage

// File: rtl/usb_gpx_sync.sv
// Multi-flop synchronizer for a single asynchronous bit, reset to 0.
module usb_gpx_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], d_i};
    end
  end

  assign q_o = sync_q[Stages-1];

endmodule

// File: rtl/usb_gpx_conditioner.sv
// Synchronizes and deglitches the GPX pin; emits edge strobes and rising-edge event tracking.
module usb_gpx_conditioner
  import usb_gpx_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SyncStagesDefault,
  parameter int unsigned FILTER_CYCLES = FilterCyclesDefault,
  parameter int unsigned CNT_W         = CntWDefault
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             gpx_async,
  input  logic             clr_events,
  output logic             gpx_level,
  output logic             gpx_rise,
  output logic             gpx_fall,
  output logic             event_sticky,
  output logic [CNT_W-1:0] event_count,
  output logic             overflow
);

  localparam int unsigned QW = $clog2(FILTER_CYCLES + 1);
  localparam logic [QW-1:0] QLast = QW'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic s;

  usb_gpx_sync #(
    .Stages(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d_i    (gpx_async),
    .q_o    (s)
  );

  gpx_state_e       state_q, state_d;
  logic [QW-1:0]    qual_q, qual_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    unique case (state_q)
      StLo: begin
        if (s) begin
          if (FILTER_CYCLES == 1) begin
            state_d = StHi;
          end else begin
            state_d = StQualHi;
            qual_d  = QW'(1);
          end
        end
      end
      StQualHi: begin
        if (!s) begin
          state_d = StLo;
          qual_d  = '0;
        end else if (qual_q == QLast) begin
          state_d = StHi;
          qual_d  = '0;
        end else begin
          qual_d = qual_q + QW'(1);
        end
      end
      StHi: begin
        if (!s) begin
          if (FILTER_CYCLES == 1) begin
            state_d = StLo;
          end else begin
            state_d = StQualLo;
            qual_d  = QW'(1);
          end
        end
      end
      StQualLo: begin
        if (s) begin
          state_d = StHi;
          qual_d  = '0;
        end else if (qual_q == QLast) begin
          state_d = StLo;
          qual_d  = '0;
        end else begin
          qual_d = qual_q + QW'(1);
        end
      end
      default: begin
        state_d = StLo;
        qual_d  = '0;
      end
    endcase
  end

  // Level and strobes are registered from the next state so they move on the accepting edge.
  always_comb begin
    level_d  = (state_d == StHi) || (state_d == StQualLo);
    rise_d   = level_d & ~level_q;
    fall_d   = ~level_d & level_q;
    sticky_d = sticky_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (rise_d) begin
      sticky_d = 1'b1;
      if (clr_events) begin
        count_d = CNT_W'(1);
        ovf_d   = 1'b0;
      end else if (count_q == CntMax) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (clr_events) begin
      sticky_d = 1'b0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StLo;
      qual_q   <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      sticky_q <= 1'b0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      qual_q   <= qual_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      sticky_q <= sticky_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign gpx_level    = level_q;
  assign gpx_rise     = rise_q;
  assign gpx_fall     = fall_q;
  assign event_sticky = sticky_q;
  assign event_count  = count_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Self-checking bench: default-width and 2-bit-counter conditioners against a run-length model.
module tb_usb_gpx_conditioner;

  localparam int S = 2;
  localparam int F = 4;

  logic clk;
  logic reset_n;
  logic pin;
  logic clr;

  logic       lvl8, rise8, fall8, stk8, ovf8;
  logic [7:0] cnt8;
  logic       lvl2, rise2, fall2, stk2, ovf2;
  logic [1:0] cnt2;

  int n_cmp;
  int n_fail;

  usb_gpx_conditioner dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .gpx_async   (pin),
    .clr_events  (clr),
    .gpx_level   (lvl8),
    .gpx_rise    (rise8),
    .gpx_fall    (fall8),
    .event_sticky(stk8),
    .event_count (cnt8),
    .overflow    (ovf8)
  );

  usb_gpx_conditioner #(
    .CNT_W(2)
  ) dut_sat (
    .clk         (clk),
    .reset_n     (reset_n),
    .gpx_async   (pin),
    .clr_events  (clr),
    .gpx_level   (lvl2),
    .gpx_rise    (rise2),
    .gpx_fall    (fall2),
    .event_sticky(stk2),
    .event_count (cnt2),
    .overflow    (ovf2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: level flips once F consecutive synchronized samples disagree with it.
  bit pipe_m[$];
  int run_m;
  bit level_m, rise_m, fall_m, sticky_m, o8_m, o2_m;
  int c8_m, c2_m;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_m.delete();
      for (int i = 0; i < S; i++) pipe_m.push_back(1'b0);
      run_m = 0; level_m = 0; rise_m = 0; fall_m = 0;
      sticky_m = 0; c8_m = 0; o8_m = 0; c2_m = 0; o2_m = 0;
    end else begin
      bit s, old;
      s = pipe_m[S-1];
      void'(pipe_m.pop_back());
      pipe_m.push_front(pin);
      old = level_m;
      run_m = (s != level_m) ? run_m + 1 : 0;
      if (run_m == F) begin
        level_m = s;
        run_m = 0;
      end
      rise_m = level_m & ~old;
      fall_m = ~level_m & old;
      if (rise_m) begin
        sticky_m = 1;
        if (clr) begin
          c8_m = 1; o8_m = 0; c2_m = 1; o2_m = 0;
        end else begin
          if (c8_m == 255) o8_m = 1; else c8_m++;
          if (c2_m == 3) o2_m = 1; else c2_m++;
        end
      end else if (clr) begin
        sticky_m = 0; c8_m = 0; o8_m = 0; c2_m = 0; o2_m = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [12:0] act8, exp8;
    logic [6:0]  act2, exp2;
    act8 = {lvl8, rise8, fall8, stk8, ovf8, cnt8};
    exp8 = {level_m, rise_m, fall_m, sticky_m, o8_m, 8'(c8_m)};
    act2 = {lvl2, rise2, fall2, stk2, ovf2, cnt2};
    exp2 = {level_m, rise_m, fall_m, sticky_m, o2_m, 2'(c2_m)};
    n_cmp++;
    if (act8 !== exp8) begin
      n_fail++;
      $display("FAIL model_cmp8 @%0t: got lvl/rise/fall/stk/ovf/cnt=%b expected %b",
               $time, act8, exp8);
    end
    n_cmp++;
    if (act2 !== exp2) begin
      n_fail++;
      $display("FAIL model_cmp2 @%0t: got lvl/rise/fall/stk/ovf/cnt=%b expected %b",
               $time, act2, exp2);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    pin = 1'b1;
    step(4);
    pin = 1'b0;
    step(12);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset_n = 1'b0;
    pin = 1'b0;
    clr = 1'b0;
    step(2);
    check("reset_level", {31'd0, lvl8}, 0);
    check("reset_count", {24'd0, cnt8}, 0);
    check("reset_flags", {28'd0, rise8, fall8, stk8, ovf8}, 0);
    reset_n = 1'b1;
    step(2);

    // Three-sample glitch is rejected.
    pin = 1'b1;
    step(3);
    pin = 1'b0;
    step(10);
    check("glitch3_level", {31'd0, lvl8}, 0);
    check("glitch3_count", {24'd0, cnt8}, 0);

    // Clean rise: level moves after edge k+5.
    pin = 1'b1;
    step(5);
    check("rise_not_early", {31'd0, lvl8}, 0);
    step(1);
    check("rise_level", {31'd0, lvl8}, 1);
    check("rise_strobe", {31'd0, rise8}, 1);
    check("rise_count", {24'd0, cnt8}, 1);
    check("rise_sticky", {31'd0, stk8}, 1);
    step(1);
    check("rise_one_cycle", {31'd0, rise8}, 0);

    // Fall leaves event registers alone.
    pin = 1'b0;
    step(6);
    check("fall_strobe", {30'd0, fall8, lvl8}, 2);
    check("fall_count", {24'd0, cnt8}, 1);
    step(1);
    check("fall_one_cycle", {31'd0, fall8}, 0);

    // Four-sample pulse qualifies.
    pin = 1'b1;
    step(4);
    pin = 1'b0;
    step(2);
    check("pulse4_level", {31'd0, lvl8}, 1);
    check("pulse4_count", {24'd0, cnt8}, 2);
    step(10);

    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("clear_count", {24'd0, cnt8}, 0);
    check("clear_flags", {30'd0, stk8, ovf8}, 0);

    // Saturation of the 2-bit counter.
    repeat (3) pulse();
    check("sat3_count2", {30'd0, cnt2}, 3);
    check("sat3_ovf2", {31'd0, ovf2}, 0);
    pulse();
    check("sat4_count2", {30'd0, cnt2}, 3);
    check("sat4_ovf2", {31'd0, ovf2}, 1);
    pulse();
    check("five_rises_count8", {24'd0, cnt8}, 5);

    // Clear on the same edge as a rise: the rise wins.
    pin = 1'b1;
    step(5);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("collide_rise", {31'd0, rise8}, 1);
    check("collide_count8", {24'd0, cnt8}, 1);
    check("collide_sticky", {31'd0, stk8}, 1);
    check("collide_count2", {30'd0, cnt2}, 1);
    check("collide_ovf2", {31'd0, ovf2}, 0);
    pin = 1'b0;
    step(12);

    repeat (3) pulse();
    check("resat_ovf2", {31'd0, ovf2}, 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("sat_clear2", {28'd0, stk2, ovf2, cnt2}, 0);
    check("sat_clear8", {23'd0, stk8, cnt8}, 0);

    pulse();
    check("pre_reset_count", {24'd0, cnt8}, 1);

    // Reset while qualifying a rise.
    pin = 1'b1;
    step(4);
    #2 reset_n = 1'b0;
    #1;
    check("midqual_reset_outs", {19'd0, lvl8, rise8, fall8, stk8, ovf8, cnt8}, 0);
    step(2);
    reset_n = 1'b1;
    step(5);
    check("post_reset_not_early", {31'd0, lvl8}, 0);
    step(1);
    check("post_reset_rise", {30'd0, lvl8, rise8}, 3);
    check("post_reset_count", {24'd0, cnt8}, 1);
    step(10);
    check("post_reset_single", {24'd0, cnt8}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_gpx_conditioner.md
# usb_gpx_conditioner

Conditions the asynchronous GPX pin from the USB host controller before it reaches the 1-bit GPX input PIO. It synchronizes and deglitches the pin and drives the clean level to the PIO `in_port`. It also produces single-cycle edge strobes, a sticky event flag and a saturating rising-edge counter, which the USB interrupt logic and debug taps use.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer flop count; legal values ≥ 2.
- `FILTER_CYCLES`, default 4: consecutive differing synchronized samples needed to accept a new level; legal values ≥ 1.
- `CNT_W`, default 8: width of the rising-edge event counter; legal values ≥ 1.

Ports:
- `clk`  in  1: system clock. Every flop is on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `gpx_async`  in  1: raw GPX pin, asynchronous to `clk`.
- `clr_events`  in  1: synchronous one-cycle clear of `event_sticky`, `event_count` and `overflow`.
- `gpx_level`  out  1: deglitched level; drives the PIO `in_port`.
- `gpx_rise`  out  1: one-cycle strobe when `gpx_level` goes 0→1.
- `gpx_fall`  out  1: one-cycle strobe when `gpx_level` goes 1→0.
- `event_sticky`  out  1: set by each accepted rise; held until cleared.
- `event_count`  out  `CNT_W`: count of accepted rises, saturating at 2^CNT_W−1.
- `overflow`  out  1: sticky; set when a rise arrives while `event_count` is already at max.

## Operation
- **Synchronizer:** a `SYNC_STAGES`-deep flop chain, reset to 0; its output is `s`.
- **FSM states:** `LO`, `QUAL_HI`, `HI`, `QUAL_LO`. The reset state is `LO` and the qualification counter `q` resets to 0.
  - `LO`: if `s`=1, go to `QUAL_HI` with `q`=1. If `FILTER_CYCLES`=1, go straight to `HI` instead.
  - `QUAL_HI`: if `s`=0, return to `LO` and set `q`=0 (glitch rejected). Otherwise increment `q`; when `s`=1 and `q`=`FILTER_CYCLES`−1, go to `HI`.
  - `HI` and `QUAL_LO`: mirror images of the two rules above.
- **Level output:** `gpx_level` is registered and equals 1 exactly in `HI` and `QUAL_LO`.
- **Edge strobes:** `gpx_rise` and `gpx_fall` are registered. Each is high for exactly the one cycle in which `gpx_level` first shows its new value. They are never both high.
- **Event logic**, evaluated on the same edge that asserts `gpx_rise`:
  - `event_sticky` is set to 1.
  - `event_count` increments unless it is at max. If it is at max, `overflow` is set to 1 and the count holds.
- **Clear:** `clr_events`=1 with no rise on that edge sets `event_sticky`=0, `event_count`=0 and `overflow`=0.
- **Clear and rise on the same edge:** the rise wins. Result is `event_sticky`=1, `event_count`=1, `overflow`=0.
- A fall never changes the event registers.
- The `q` width is $clog2(`FILTER_CYCLES`+1). `q` never exceeds `FILTER_CYCLES`−1.

## Timing
- **Reset values** (asynchronous, immediate): `gpx_level`=0, `gpx_rise`=0, `gpx_fall`=0, `event_sticky`=0, `event_count`=0, `overflow`=0. The FSM is in `LO` and the synchronizer holds 0.
- **Latency:** the pin is first sampled at edge k. `gpx_level` and the strobe change after edge k+`SYNC_STAGES`+`FILTER_CYCLES`−1. With defaults, that is 5 edges after the first sampling edge.
- **Glitch rejection:** a pulse seen as fewer than `FILTER_CYCLES` consecutive synchronized samples produces no output change and no event.
- **Pin level while reset is held:** if the pin is high when `reset_n` deasserts, a normal qualified rise follows and is counted as an event.
- **Reset during qualification:** the qualification is abandoned and no strobe is produced.
- `clr_events` takes effect on the next edge; there is no other latency.

## Structure
- **Shared package `usb_gpx_pkg`:** FSM state enum (`LO`, `QUAL_HI`, `HI`, `QUAL_LO`) and default parameter constants.
- **Sub-module `usb_gpx_sync`:** a parameterized synchronizer chain with asynchronous reset to 0. It is instantiated once.
- All remaining logic is in `usb_gpx_conditioner`.

## Test plan
- **Clean rise, defaults:** drive the pin 0→1 and hold. Required: `gpx_level`=1 and a single `gpx_rise` after 5 edges past the first sampling edge; `event_count`=1; `event_sticky`=1.
- **Glitch:** pin high for 3 sampled cycles, then low. Required: `gpx_level` stays 0, no strobes, `event_count`=0. Repeat with a 4-cycle pulse; required: `gpx_level` goes high and counts.
- **Fall:** from `HI`, pin goes 0. Required: one `gpx_fall` pulse, `gpx_level`=0, event registers unchanged.
- **Clear collision:** assert `clr_events` on the same edge as `gpx_rise` with `event_count`=5. Required: `event_count`=1, `event_sticky`=1. Clear alone then gives all zeros.
- **Saturation, `CNT_W`=2:** 5 qualified rises. Required: `event_count`=3 and `overflow`=1 after the 4th rise; a clear resets all three registers.
- **Reset mid-qualification:** assert `reset_n`=0 while in `QUAL_HI`. Required: all outputs 0 immediately. After release with the pin held high, exactly one qualified rise is produced.
